// File: rtl/host_req_arbiter.sv
// host_req_arbiter: round-robin arbiter merging NCORES request ports onto one
// registered host request stage. Host responses are routed back to the core
// named by host_resp_id. Each core may have at most one request outstanding.
module host_req_arbiter #(
    parameter int NCORES = 2,
    parameter int IDW    = $clog2(NCORES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    core_req_valid,
    output logic [NCORES-1:0]    core_req_ready,
    input  logic [64*NCORES-1:0] core_req,
    output logic [NCORES-1:0]    core_resp_valid,
    input  logic [NCORES-1:0]    core_resp_ready,
    output logic [63:0]          core_resp,
    output logic                 host_req_valid,
    input  logic                 host_req_ready,
    output logic [IDW-1:0]       host_req_id,
    output logic [63:0]          host_req,
    input  logic                 host_resp_valid,
    output logic                 host_resp_ready,
    input  logic [IDW-1:0]       host_resp_id,
    input  logic [63:0]          host_resp,
    output logic [NCORES-1:0]    pending,
    output logic                 bad_id
);

    localparam int          PW = $clog2(NCORES);
    localparam int unsigned NC = NCORES;

    logic              r_valid;
    logic [IDW-1:0]    r_id;
    logic [63:0]       r_data;
    logic [NCORES-1:0] r_pending;
    logic [PW-1:0]     r_rr_ptr;
    logic              r_bad_id;

    logic [NCORES-1:0] w_elig;
    logic              w_can_load;
    logic              w_hi_found;
    logic              w_lo_found;
    logic [PW-1:0]     w_hi_win;
    logic [PW-1:0]     w_lo_win;
    logic              w_found;
    logic [PW-1:0]     w_win;
    logic              w_load;
    logic [63:0]       w_win_data;
    logic              w_rid_ok;
    logic              w_sel_ready;
    logic [NCORES-1:0] w_resp_clr;

    assign w_elig     = core_req_valid & ~r_pending;
    assign w_can_load = !r_valid || host_req_ready;

    // Round-robin pick: prefer the lowest eligible core at or above the
    // pointer; otherwise wrap and take the lowest eligible core below it.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_win   = '0;
        w_lo_win   = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (w_elig[i]) begin
                if (i >= 32'(r_rr_ptr)) begin
                    if (!w_hi_found) begin
                        w_hi_found = 1'b1;
                        w_hi_win   = PW'(i);
                    end
                end else if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_win   = PW'(i);
                end
            end
        end
        w_found = w_hi_found || w_lo_found;
        w_win   = w_hi_found ? w_hi_win : w_lo_win;
        w_load  = w_found && w_can_load && !rst;
    end

    // One-hot accept toward the winning core and its request data.
    always_comb begin
        core_req_ready = '0;
        w_win_data     = '0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (w_win == PW'(i)) begin
                core_req_ready[i] = w_load;
                w_win_data        = core_req[64*i +: 64];
            end
        end
    end

    // Response routing by id; out-of-range ids are absorbed and dropped.
    always_comb begin
        core_resp_valid = '0;
        w_sel_ready     = 1'b0;
        w_rid_ok        = 32'(host_resp_id) < NC;
        for (int unsigned i = 0; i < NC; i++) begin
            if (32'(host_resp_id) == i) begin
                core_resp_valid[i] = host_resp_valid;
                w_sel_ready        = core_resp_ready[i];
            end
        end
        host_resp_ready = !rst && (w_rid_ok ? w_sel_ready : 1'b1);
        w_resp_clr      = core_resp_valid & core_resp_ready;
    end

    assign core_resp = host_resp;

    // Output entry, pending flags, round-robin pointer and sticky bad-id flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_data    <= '0;
            r_pending <= '0;
            r_rr_ptr  <= '0;
            r_bad_id  <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid  <= 1'b1;
                r_id     <= IDW'(w_win);
                r_data   <= w_win_data;
                r_rr_ptr <= (w_win == PW'(NCORES-1)) ? '0 : w_win + PW'(1);
            end else if (r_valid && host_req_ready) begin
                r_valid <= 1'b0;
            end
            // Clear before set: a core can only win while its flag is low,
            // so a same-core clear never races a set in one cycle.
            r_pending <= (r_pending & ~w_resp_clr) | core_req_ready;
            r_bad_id  <= r_bad_id | (host_resp_valid && !w_rid_ok);
        end
    end

    assign host_req_valid = r_valid;
    assign host_req_id    = r_id;
    assign host_req       = r_data;
    assign pending        = r_pending;
    assign bad_id         = r_bad_id;

endmodule

// File: tb/tb_host_req_arbiter.sv
// tb_host_req_arbiter: directed scenarios plus randomized traffic, checked
// cycle by cycle against a behavioural model of the arbiter rules.
module tb_host_req_arbiter;

    localparam int N   = 3;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      core_req_valid;
    logic [N-1:0]      core_req_ready;
    logic [64*N-1:0]   core_req;
    logic [N-1:0]      core_resp_valid;
    logic [N-1:0]      core_resp_ready;
    logic [63:0]       core_resp;
    logic              host_req_valid;
    logic              host_req_ready;
    logic [IDW-1:0]    host_req_id;
    logic [63:0]       host_req;
    logic              host_resp_valid;
    logic              host_resp_ready;
    logic [IDW-1:0]    host_resp_id;
    logic [63:0]       host_resp;
    logic [N-1:0]      pending;
    logic              bad_id;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    bit          m_valid;
    int unsigned m_id;
    logic [63:0] m_data;
    bit          m_pend [N];
    int unsigned m_rr;
    bit          m_bad;

    always #5 clk = ~clk;

    host_req_arbiter #(.NCORES(N), .IDW(IDW)) dut (
        .clk             (clk),
        .rst             (rst),
        .core_req_valid  (core_req_valid),
        .core_req_ready  (core_req_ready),
        .core_req        (core_req),
        .core_resp_valid (core_resp_valid),
        .core_resp_ready (core_resp_ready),
        .core_resp       (core_resp),
        .host_req_valid  (host_req_valid),
        .host_req_ready  (host_req_ready),
        .host_req_id     (host_req_id),
        .host_req        (host_req),
        .host_resp_valid (host_resp_valid),
        .host_resp_ready (host_resp_ready),
        .host_resp_id    (host_resp_id),
        .host_resp       (host_resp),
        .pending         (pending),
        .bad_id          (bad_id)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_data = '0; m_rr = 0; m_bad = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 0;
    endtask

    function automatic logic [N-1:0] pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic randomize_data();
        for (int c = 0; c < N; c++) core_req[64*c +: 64] = {$urandom(), $urandom()};
        host_resp = {$urandom(), $urandom()};
    endtask

    // Check the current cycle against the model, advance the model across
    // the next rising edge, and return 1 time unit after that edge.
    task automatic step();
        bit           can_load;
        bit           found;
        int unsigned  w;
        int unsigned  rid;
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_crv;
        bit           e_hrr;
        #1;
        check("host_req_valid", 64'(host_req_valid), 64'(m_valid));
        if (m_valid) begin
            check("host_req_id", 64'(host_req_id), 64'(m_id));
            check("host_req", host_req, m_data);
        end
        check("pending", 64'(pending), 64'(pend_vec()));
        check("bad_id", 64'(bad_id), 64'(m_bad));

        can_load = !m_valid || host_req_ready;
        found = 0;
        w = 0;
        for (int k = 0; k < N; k++) begin
            int unsigned c;
            c = (m_rr + k) % N;
            if (!found && core_req_valid[c] && !m_pend[c]) begin
                found = 1;
                w = c;
            end
        end
        e_rdy = (!rst && can_load && found) ? N'(1 << w) : '0;

        rid = int'(host_resp_id);
        if (rid < N) begin
            e_crv = host_resp_valid ? N'(1 << rid) : '0;
            e_hrr = !rst && core_resp_ready[rid];
        end else begin
            e_crv = '0;
            e_hrr = !rst;
        end
        check("core_req_ready", 64'(core_req_ready), 64'(e_rdy));
        check("core_resp_valid", 64'(core_resp_valid), 64'(e_crv));
        check("host_resp_ready", 64'(host_resp_ready), 64'(e_hrr));
        check("core_resp", core_resp, host_resp);

        if (rst) begin
            model_reset();
        end else begin
            if (host_resp_valid && e_hrr && rid < N) m_pend[rid] = 0;
            if (host_resp_valid && rid >= N) m_bad = 1;
            if (e_rdy != '0) begin
                m_valid = 1;
                m_id    = w;
                m_data  = core_req[64*w +: 64];
                m_pend[w] = 1;
                m_rr    = (w + 1) % N;
            end else if (m_valid && host_req_ready) begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_req_valid  = '0;
        core_resp_ready = '0;
        host_req_ready  = 1'b0;
        host_resp_valid = 1'b0;
        host_resp_id    = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        randomize_data();
        @(posedge clk);
        #1;
        model_reset();
        step();
        rst = 1'b0;

        // Two cores requesting after reset: grants 0 then 1.
        core_req_valid = 3'b011;
        host_req_ready = 1'b1;
        step();
        check("first_id", 64'(host_req_id), 64'd0);
        step();
        check("second_id", 64'(host_req_id), 64'd1);
        check("pend_both", 64'(pending), 64'h3);
        core_req_valid = '0;

        // Return both responses, then stall a loaded entry for 5 cycles.
        host_resp_valid = 1'b1;
        core_resp_ready = 3'b111;
        host_resp_id = 2'd0;
        step();
        host_resp_id = 2'd1;
        step();
        idle_inputs();
        core_req[127:64] = 64'hDEAD_BEEF;
        core_req_valid = 3'b010;
        step();
        core_req_valid = 3'b111;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_id", 64'(host_req_id), 64'd1);
            check("stall_data", host_req, 64'hDEAD_BEEF);
            check("stall_valid", 64'(host_req_valid), 64'd1);
        end
        host_req_ready = 1'b1;
        step();
        check("after_stall_id", 64'(host_req_id), 64'd2);

        // Same-cycle response and request for core 0.
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        host_req_ready = 1'b1;
        core_req_valid = 3'b001;
        step();
        host_resp_valid = 1'b1;
        host_resp_id    = 2'd0;
        core_resp_ready = 3'b001;
        step();
        check("p0_cleared", 64'(pending), 64'd0);
        host_resp_valid = 1'b0;
        step();
        check("p0_regrant", 64'(pending), 64'd1);

        // Invalid response id sets the sticky error flag.
        core_req_valid  = '0;
        host_resp_valid = 1'b1;
        host_resp_id    = 2'd3;
        core_resp_ready = '0;
        step();
        host_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("bad_sticky", 64'(bad_id), 64'd1);

        // Reset with a loaded entry and outstanding requests.
        host_req_ready = 1'b0;
        core_req_valid = 3'b111;
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_valid", 64'(host_req_valid), 64'd0);
        check("rst_pend", 64'(pending), 64'd0);
        check("rst_bad", 64'(bad_id), 64'd0);
        rst = 1'b0;
        host_req_ready = 1'b1;
        core_req_valid = 3'b110;
        core_req_valid[0] = 1'b1;
        step();
        check("post_rst_grant", 64'(host_req_id), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 99) == 0);
            core_req_valid  = N'($urandom());
            core_resp_ready = N'($urandom());
            host_req_ready  = ($urandom_range(0, 3) != 0);
            host_resp_valid = ($urandom_range(0, 1) != 0);
            host_resp_id    = IDW'($urandom_range(0, 3));
            randomize_data();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/host_req_arbiter.md
HOST_REQ_ARBITER -- requirements
Module: host_req_arbiter

Interface
REQ-001 Parameter NCORES, default 2, number of core request ports, legal range 2..16.
REQ-002 Parameter IDW, default $clog2(NCORES), width of host-side id fields.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 core_req_valid  input  NCORES  per-core request valid.
REQ-006 core_req_ready  output  NCORES  per-core request accept.
REQ-007 core_req  input  64*NCORES  per-core request data; core i occupies bits [64*i+63:64*i].
REQ-008 core_resp_valid  output  NCORES  per-core response valid.
REQ-009 core_resp_ready  input  NCORES  per-core response accept.
REQ-010 core_resp  output  64  response data, broadcast to all cores.
REQ-011 host_req_valid  output  1  request valid toward the host stage.
REQ-012 host_req_ready  input  1  host accepts the request.
REQ-013 host_req_id  output  IDW  index of the originating core.
REQ-014 host_req  output  64  request data.
REQ-015 host_resp_valid  input  1  response valid from the host stage.
REQ-016 host_resp_ready  output  1  arbiter accepts the response.
REQ-017 host_resp_id  input  IDW  destination core index.
REQ-018 host_resp  input  64  response data.
REQ-019 pending  output  NCORES  per-core outstanding-request flags.
REQ-020 bad_id  output  1  sticky flag: a response arrived with an id >= NCORES.

Function
REQ-021 A handshake occurs on any channel only in a cycle where its valid and ready are both 1 at posedge clk.
REQ-022 Output stage: one registered entry {host_req_valid, host_req_id, host_req}; the entry may load a new request when host_req_valid=0 or when host_req_ready=1 in the same cycle (full-throughput drain and refill).
REQ-023 Eligibility: core i is eligible when core_req_valid[i]=1 and the registered pending[i]=0.
REQ-024 Arbitration: round-robin starting at pointer rr_ptr; the winner is the first eligible core at or after rr_ptr, searching upward with wrap from NCORES-1 to 0.
REQ-025 core_req_ready[i] is 1 only when core i is the winner and the output entry may load; it is combinational from current-cycle inputs and state, and at most one bit is set.
REQ-026 On a core handshake from core i: the entry loads {1, i, core_req[i]}, pending[i] sets, and rr_ptr becomes i+1 (wrapping to 0 after NCORES-1).
REQ-027 Latency: a core handshake at posedge t makes host_req_valid=1 with that core's data from t onward.
REQ-028 The entry holds host_req_id and host_req stable while host_req_valid=1 and host_req_ready=0.
REQ-029 A host handshake with no new winner in the same cycle clears host_req_valid.
REQ-030 Response routing for host_resp_id < NCORES:
  - core_resp_valid[host_resp_id] = host_resp_valid;
  - all other core_resp_valid bits are 0;
  - host_resp_ready = core_resp_ready[host_resp_id];
  - core_resp = host_resp.
  All four are purely combinational, with zero latency.
REQ-031 A response handshake to core i clears pending[i].
REQ-032 Invalid id (host_resp_id >= NCORES):
  - host_resp_ready=1;
  - all core_resp_valid bits are 0;
  - the response is dropped;
  - bad_id sets when host_resp_valid=1.
REQ-033 Simultaneous events, same core, same cycle:
  - if a response clears pending[i], core i stays ineligible that cycle;
  - its request can be accepted in the next cycle at the earliest.
REQ-034 Responses are never blocked by request-side activity; request and response paths operate concurrently.

Reset
REQ-035 While rst=1 at posedge clk:
  - host_req_valid=0, host_req_id=0, host_req=0;
  - pending=0, rr_ptr=0, bad_id=0.
REQ-036 During the cycle rst=1: core_req_ready=0 and host_resp_ready=0; core_resp_valid follows REQ-030.
REQ-037 Reset asserted mid-operation discards any buffered request and all pending flags; no host handshake is issued for the discarded entry after rst deasserts.
REQ-038 bad_id is cleared only by rst.

Verification
REQ-039 Both cores valid after reset, host_req_ready=1 → core 0 granted at t0 and core 1 at t1; host_req_id sequence 0,1; pending=2'b11 after t1.
REQ-040 host_req_ready=0 for 5 cycles with entry loaded (id 1, data 64'hDEAD_BEEF) → outputs held stable and core_req_ready=0 for the whole stall; the entry is accepted on the first ready cycle.
REQ-041 Core 0 pending, host_resp_valid=1, host_resp_id=0, core_resp_ready[0]=1 with core_req_valid[0]=1 in the same cycle → pending[0] clears at that edge; core 0 is granted in the next cycle, not the same cycle.
REQ-042 NCORES=3 with host_resp_id=3 → host_resp_ready=1, core_resp_valid=0, bad_id=1 and sticky until rst.
REQ-043 rst asserted while host_req_valid=1 and pending≠0 → all outputs and pending return to 0 in the next cycle; the first grant after reset goes to core 0.
